// File: rtl/inst_fetch_unit_if.sv
// Instruction-fetch bus bundle: redirect/stall controls, ROM-style memory port and IF/ID outputs.
// master: the fetch unit (drives rom_* requests and id_*; samples controls and rom_read_data).
// slave : the surrounding pipeline/memory (drives controls and rom_read_data; samples the rest).
interface inst_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // pipeline control
    logic                  stall;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_pc;
    logic                  branch_flag;
    logic [ADDR_WIDTH-1:0] branch_addr;
    // instruction memory port (read data is combinational on rom_addr)
    logic                  rom_en;
    logic [3:0]            rom_write_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_write_data;
    logic [DATA_WIDTH-1:0] rom_read_data;
    // IF/ID pipeline register
    logic [ADDR_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_inst;
    logic                  id_valid;
    logic                  id_adel;

    modport master (
        input  stall, flush, flush_pc, branch_flag, branch_addr, rom_read_data,
        output rom_en, rom_write_en, rom_addr, rom_write_data,
        output id_pc, id_inst, id_valid, id_adel
    );

    modport slave (
        output stall, flush, flush_pc, branch_flag, branch_addr, rom_read_data,
        input  rom_en, rom_write_en, rom_addr, rom_write_data,
        input  id_pc, id_inst, id_valid, id_adel
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a zero-latency ROM port and fills the IF/ID register.
// Ports: clk, rst (sync, active-high), bus (inst_fetch_unit_if.master: controls in, rom_* out, id_* out).
// Fetch commits in the same cycle as the address; stall freezes PC and IF/ID, a branch seen
// during a stall is remembered and applied after the delay slot commits.
module inst_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] INIT_PC    = 32'hbfc00000
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_unit_if.master   bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  br_pend;
    logic [ADDR_WIDTH-1:0] br_target;

    logic [ADDR_WIDTH-1:0] id_pc;
    logic [DATA_WIDTH-1:0] id_inst;
    logic                  id_valid;
    logic                  id_adel;

    logic                  aligned;
    logic [DATA_WIDTH-1:0] fetch_word;
    logic [ADDR_WIDTH-1:0] next_pc;

    assign aligned    = (pc[1:0] == 2'b00);
    // A misaligned fetch never reaches memory, so its instruction slot is zeroed.
    assign fetch_word = aligned ? bus.rom_read_data : '0;

    // Redirect priority: exception flush, then a branch remembered across a stall,
    // then a branch resolved this cycle, then sequential (wraps modulo 2^ADDR_WIDTH).
    always_comb begin
        next_pc = pc + ADDR_WIDTH'(4);
        if (bus.flush) begin
            next_pc = bus.flush_pc;
        end else if (br_pend) begin
            next_pc = br_target;
        end else if (bus.branch_flag) begin
            next_pc = bus.branch_addr;
        end
    end

    assign bus.rom_en         = (state == RUN) && !bus.stall && aligned;
    assign bus.rom_addr       = pc;
    assign bus.rom_write_en   = 4'b0000;
    assign bus.rom_write_data = '0;

    assign bus.id_pc    = id_pc;
    assign bus.id_inst  = id_inst;
    assign bus.id_valid = id_valid;
    assign bus.id_adel  = id_adel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= INIT_PC;
            br_pend   <= 1'b0;
            br_target <= '0;
            id_pc     <= '0;
            id_inst   <= '0;
            id_valid  <= 1'b0;
            id_adel   <= 1'b0;
        end else if (state == BOOT) begin
            // One idle cycle after reset; a flush here only moves the start address.
            if (bus.flush) begin
                pc <= bus.flush_pc;
            end else if (bus.stall && bus.branch_flag) begin
                br_pend   <= 1'b1;
                br_target <= bus.branch_addr;
            end
            state <= bus.stall ? STALL : RUN;
        end else if (bus.flush) begin
            // Redirect wins over stall and branch; the IF/ID slot becomes a bubble
            // but id_pc keeps the last committed PC.
            pc       <= bus.flush_pc;
            br_pend  <= 1'b0;
            id_valid <= 1'b0;
            id_inst  <= '0;
            id_adel  <= 1'b0;
            state    <= bus.stall ? STALL : RUN;
        end else if (bus.stall || state == STALL) begin
            // No fetch while stalled, nor in the cycle the stall releases (STALL
            // returns to RUN first). A branch arriving now is held until the delay
            // slot at pc has committed; a later branch overwrites the target.
            if (bus.branch_flag) begin
                br_pend   <= 1'b1;
                br_target <= bus.branch_addr;
            end
            state <= bus.stall ? STALL : RUN;
        end else begin
            // RUN, not stalled: commit the instruction at pc.
            id_pc    <= pc;
            id_inst  <= fetch_word;
            id_adel  <= !aligned;
            id_valid <= 1'b1;
            pc       <= next_pc;
            br_pend  <= 1'b0;
            state    <= RUN;
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam logic [31:0] INIT = 32'hbfc00000;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    inst_fetch_unit_if bus ();

    inst_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INIT_PC(INIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROM contents: a fixed scramble of the address, answered combinationally.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h1234abcd;
    endfunction

    assign bus.rom_read_data = rom_word(bus.rom_addr);

    // ---------------- reference model ----------------
    // Tracks where the fetcher is, whether it is allowed to fetch this cycle,
    // an optional remembered redirect, and the last committed instruction.
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_hold;
    logic [31:0] m_redirect[$];
    logic [31:0] e_pc, e_inst;
    bit          e_valid, e_adel;

    function automatic bit model_rom_en();
        return !m_boot && !m_hold && !bus.stall && (m_pc % 4 == 0);
    endfunction

    task automatic model_step();
        if (rst) begin
            m_pc = INIT; m_boot = 1; m_hold = 0; m_redirect.delete();
            e_pc = 0; e_inst = 0; e_valid = 0; e_adel = 0;
        end else if (m_boot) begin
            if (bus.flush) m_pc = bus.flush_pc;
            else if (bus.stall && bus.branch_flag) m_redirect = '{bus.branch_addr};
            m_boot = 0;
            m_hold = bus.stall;
        end else if (bus.flush) begin
            m_pc = bus.flush_pc; m_redirect.delete();
            e_valid = 0; e_inst = 0; e_adel = 0;
            m_hold = bus.stall;
        end else if (bus.stall || m_hold) begin
            if (bus.branch_flag) m_redirect = '{bus.branch_addr};
            m_hold = bus.stall;
        end else begin
            e_pc    = m_pc;
            e_adel  = (m_pc % 4 != 0);
            e_inst  = e_adel ? 32'd0 : rom_word(m_pc);
            e_valid = 1;
            if (m_redirect.size() != 0) m_pc = m_redirect.pop_front();
            else if (bus.branch_flag)   m_pc = bus.branch_addr;
            else                        m_pc = m_pc + 32'd4;
        end
    endtask

    // One clock: edge, model update, then back to the falling edge for checks/drive.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit s, input bit f, input logic [31:0] fpc,
                         input bit b, input logic [31:0] baddr);
        bus.stall = s; bus.flush = f; bus.flush_pc = fpc;
        bus.branch_flag = b; bus.branch_addr = baddr;
        #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        int          lo;
        a = INIT + {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        if ($urandom_range(0, 9) == 0) begin
            lo = $urandom_range(1, 3);
            a[1:0] = lo[1:0];
        end
        if ($urandom_range(0, 24) == 0) a = 32'hfffffffc;
        return a;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        cyc();
        cyc();
        tests++;
        if ({bus.id_valid, bus.id_adel, bus.id_pc, bus.id_inst} !== 66'd0) begin
            fails++;
            $display("FAIL reset_id: valid=%b adel=%b pc=%h inst=%h, expected all zero",
                     bus.id_valid, bus.id_adel, bus.id_pc, bus.id_inst);
        end
        tests++;
        if (bus.rom_en !== 1'b0 || bus.rom_addr !== INIT || bus.rom_write_en !== 4'b0000 ||
            bus.rom_write_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_rom: en=%b addr=%h we=%b wd=%h, expected 0 %h 0000 0",
                     bus.rom_en, bus.rom_addr, bus.rom_write_en, bus.rom_write_data, INIT);
        end
    endtask

    task automatic test_fetch_sequence();
        rst = 1'b0;
        #1;
        tests++;
        if (bus.rom_en !== 1'b0) begin
            fails++;
            $display("FAIL boot_idle: rom_en=%b, expected 0", bus.rom_en);
        end
        cyc();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (bus.rom_en !== 1'b1 || bus.rom_addr !== INIT + 32'(4 * k)) begin
                fails++;
                $display("FAIL seq_fetch%0d: en=%b addr=%h, expected 1 %h",
                         k, bus.rom_en, bus.rom_addr, INIT + 32'(4 * k));
            end
            if (k == 2) break;
            cyc();
            tests++;
            if (bus.id_pc !== INIT + 32'(4 * k) || bus.id_valid !== 1'b1 ||
                bus.id_inst !== rom_word(INIT + 32'(4 * k))) begin
                fails++;
                $display("FAIL seq_commit%0d: pc=%h valid=%b inst=%h, expected %h 1 %h", k,
                         bus.id_pc, bus.id_valid, bus.id_inst, INIT + 32'(4 * k),
                         rom_word(INIT + 32'(4 * k)));
            end
        end
    endtask

    task automatic test_stall_hold();
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (bus.rom_en !== 1'b0 || bus.id_pc !== INIT + 32'd4 || bus.id_valid !== 1'b1 ||
                bus.id_inst !== rom_word(INIT + 32'd4)) begin
                fails++;
                $display("FAIL stall_hold%0d: en=%b id_pc=%h valid=%b inst=%h, expected 0 %h 1 %h",
                         k, bus.rom_en, bus.id_pc, bus.id_valid, bus.id_inst,
                         INIT + 32'd4, rom_word(INIT + 32'd4));
            end
            cyc();
        end
        drive(0, 0, 0, 0, 0);
        cyc();
        tests++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== INIT + 32'd8) begin
            fails++;
            $display("FAIL stall_resume: en=%b addr=%h, expected 1 %h",
                     bus.rom_en, bus.rom_addr, INIT + 32'd8);
        end
        cyc();
        tests++;
        if (bus.id_pc !== INIT + 32'd8 || bus.rom_addr !== INIT + 32'hc) begin
            fails++;
            $display("FAIL stall_once: id_pc=%h addr=%h, expected %h %h",
                     bus.id_pc, bus.rom_addr, INIT + 32'd8, INIT + 32'hc);
        end
    endtask

    task automatic test_branch_delay_slot();
        cyc();
        drive(0, 0, 0, 1, 32'hbfc00100);
        cyc();
        drive(0, 0, 0, 0, 0);
        tests++;
        if (bus.id_pc !== 32'hbfc00010 || bus.rom_addr !== 32'hbfc00100) begin
            fails++;
            $display("FAIL br_slot: id_pc=%h addr=%h, expected bfc00010 bfc00100",
                     bus.id_pc, bus.rom_addr);
        end
        cyc();
        tests++;
        if (bus.id_pc !== 32'hbfc00100) begin
            fails++;
            $display("FAIL br_target: id_pc=%h, expected bfc00100", bus.id_pc);
        end
        cyc();
        tests++;
        if (bus.id_pc !== 32'hbfc00104) begin
            fails++;
            $display("FAIL br_next: id_pc=%h, expected bfc00104", bus.id_pc);
        end
    endtask

    task automatic test_branch_in_stall();
        drive(0, 1, 32'hbfc00020, 0, 0);
        cyc();
        tests++;
        if (bus.id_valid !== 1'b0 || bus.id_pc !== 32'hbfc00104 || bus.rom_addr !== 32'hbfc00020) begin
            fails++;
            $display("FAIL flush_bubble: valid=%b id_pc=%h addr=%h, expected 0 bfc00104 bfc00020",
                     bus.id_valid, bus.id_pc, bus.rom_addr);
        end
        drive(1, 0, 0, 1, 32'hbfc00200);
        cyc();
        drive(1, 0, 0, 1, 32'hbfc00300);
        cyc();
        drive(1, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        cyc();
        tests++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== 32'hbfc00020) begin
            fails++;
            $display("FAIL bstall_slot_fetch: en=%b addr=%h, expected 1 bfc00020",
                     bus.rom_en, bus.rom_addr);
        end
        cyc();
        tests++;
        if (bus.id_pc !== 32'hbfc00020 || bus.rom_addr !== 32'hbfc00300) begin
            fails++;
            $display("FAIL bstall_redirect: id_pc=%h addr=%h, expected bfc00020 bfc00300",
                     bus.id_pc, bus.rom_addr);
        end
        cyc();
        tests++;
        if (bus.id_pc !== 32'hbfc00300) begin
            fails++;
            $display("FAIL bstall_commit: id_pc=%h, expected bfc00300", bus.id_pc);
        end
    endtask

    task automatic test_flush_priority();
        drive(1, 1, 32'hbfc00380, 1, 32'hbfc003f0);
        cyc();
        tests++;
        if (bus.id_valid !== 1'b0 || bus.id_inst !== 32'd0 || bus.id_pc !== 32'hbfc00300 ||
            bus.rom_addr !== 32'hbfc00380 || bus.rom_en !== 1'b0) begin
            fails++;
            $display("FAIL flush_prio: valid=%b inst=%h id_pc=%h addr=%h en=%b, expected 0 0 bfc00300 bfc00380 0",
                     bus.id_valid, bus.id_inst, bus.id_pc, bus.rom_addr, bus.rom_en);
        end
        drive(1, 0, 0, 0, 0);
        cyc();
        drive(0, 0, 0, 0, 0);
        cyc();
        cyc();
        tests++;
        if (bus.id_pc !== 32'hbfc00380 || bus.id_valid !== 1'b1 || bus.rom_addr !== 32'hbfc00384) begin
            fails++;
            $display("FAIL flush_resume: id_pc=%h valid=%b addr=%h, expected bfc00380 1 bfc00384",
                     bus.id_pc, bus.id_valid, bus.rom_addr);
        end
    endtask

    task automatic test_misaligned();
        drive(0, 0, 0, 1, 32'hbfc00102);
        cyc();
        drive(0, 0, 0, 0, 0);
        tests++;
        if (bus.rom_en !== 1'b0 || bus.rom_addr !== 32'hbfc00102) begin
            fails++;
            $display("FAIL adel_fetch: en=%b addr=%h, expected 0 bfc00102", bus.rom_en, bus.rom_addr);
        end
        cyc();
        tests++;
        if (bus.id_adel !== 1'b1 || bus.id_inst !== 32'd0 || bus.id_valid !== 1'b1 ||
            bus.id_pc !== 32'hbfc00102 || bus.rom_addr !== 32'hbfc00106) begin
            fails++;
            $display("FAIL adel_commit: adel=%b inst=%h valid=%b id_pc=%h addr=%h, expected 1 0 1 bfc00102 bfc00106",
                     bus.id_adel, bus.id_inst, bus.id_valid, bus.id_pc, bus.rom_addr);
        end
    endtask

    task automatic test_reset_while_stalled();
        drive(1, 0, 0, 1, 32'hbfc00500);
        cyc();
        rst = 1'b1;
        drive(1, 0, 0, 0, 0);
        cyc();
        tests++;
        if ({bus.id_valid, bus.id_adel, bus.id_pc, bus.id_inst} !== 66'd0 ||
            bus.rom_addr !== INIT || bus.rom_en !== 1'b0) begin
            fails++;
            $display("FAIL rst_stalled: valid=%b adel=%b id_pc=%h inst=%h addr=%h en=%b, expected zeros, addr %h",
                     bus.id_valid, bus.id_adel, bus.id_pc, bus.id_inst, bus.rom_addr, bus.rom_en, INIT);
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        cyc();
        cyc();
        tests++;
        if (bus.id_pc !== INIT || bus.rom_addr !== INIT + 32'd4) begin
            fails++;
            $display("FAIL rst_pend_cleared: id_pc=%h addr=%h, expected %h %h",
                     bus.id_pc, bus.rom_addr, INIT, INIT + 32'd4);
        end
    endtask

    task automatic test_random();
        int  shown;
        bit  exp_en;
        shown = 0;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, rnd_addr(),
                  $urandom_range(0, 5) == 0, rnd_addr());
            exp_en = model_rom_en();
            tests++;
            if (bus.rom_en !== exp_en || bus.rom_addr !== m_pc) begin
                fails++;
                if (shown < 10)
                    $display("FAIL rand_fetch cycle %0d: en=%b addr=%h, expected %b %h",
                             i, bus.rom_en, bus.rom_addr, exp_en, m_pc);
                shown++;
            end
            cyc();
            tests++;
            if (bus.id_valid !== e_valid || bus.id_adel !== e_adel ||
                bus.id_pc !== e_pc || bus.id_inst !== e_inst) begin
                fails++;
                if (shown < 10)
                    $display("FAIL rand_ifid cycle %0d: valid=%b adel=%b pc=%h inst=%h, expected %b %b %h %h",
                             i, bus.id_valid, bus.id_adel, bus.id_pc, bus.id_inst,
                             e_valid, e_adel, e_pc, e_inst);
                shown++;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_pc = INIT; m_boot = 1; m_hold = 0;
        e_pc = 0; e_inst = 0; e_valid = 0; e_adel = 0;
        test_reset();
        test_fetch_sequence();
        test_stall_hold();
        test_branch_delay_slot();
        test_branch_in_stall();
        test_flush_priority();
        test_misaligned();
        test_reset_while_stalled();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
